csc_matrix_pipe: RTL and testbench
==================================

Name: csc_matrix_pipe

Overview:
Parametrised, pipelined 3x3 colour-space converter, the successor to the fixed RGB->YCbCr front end in processing. It computes out_i = round(sum_j c_ij*x_j) + off_i per pixel, then clamps to the unsigned output range. Coefficients and offsets are runtime-loadable through a shadow bank, and the bank swaps only at a frame boundary. It sits between the pixel source and the filter stage and carries its own frame-done tracking.

Parameters:
DATA_W, 8, unsigned bits per input channel
OUT_W, 8, unsigned bits per output channel
COEF_W, 18, signed coefficient width
COEF_FRAC, 17, fractional bits in coefficients
OFF_W, 10, signed offset width (integer output units)
FRAME_PIXELS, 307200, pixels per frame (counter terminal value)

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-low reset
iValid  in  1  input pixel valid; every valid cycle is accepted; no backpressure
iData  in  3*DATA_W  {X,Y,Z}; X in MSBs
iCfgWe  in  1  shadow-bank write strobe
iCfgAddr  in  4  0..8 = c00,c01,c02,c10..c22 row-major; 9..11 = off0..off2
iCfgData  in  COEF_W  write data; offsets use low OFF_W bits
iCfgCommit  in  1  request shadow->active swap
oData  out  3*OUT_W  {A,B,C} clamped results
oValid  out  1  output valid
oDone  out  1  one-cycle pulse with oValid of the last pixel of a frame
oCfgPending  out  1  commit requested, swap not yet done

Behaviour:
- Reset (reset=0, async): oValid=0, oDone=0, oCfgPending=0, oData=0. Pipeline valids and both pixel counters clear. Active and shadow banks load the BT.601 defaults: rows {39164,76926,14982}, {-22138,-43398,65536}, {65536,-54906,-10630}; offsets {0,128,128}.
- Latency is exactly 4 cycles from iValid to oValid, fully pipelined at 1 pixel/clk.
  - S1: register inputs, zero-extended to DATA_W+1 signed, plus a snapshot of the active coefs and offsets.
  - S2: 9 products, each DATA_W+1+COEF_W bits, registered.
  - S3: row sums with 2 guard bits; add 2^(COEF_FRAC-1), then arithmetic shift right by COEF_FRAC (round half up).
  - S4: add the offset carried from S1, clamp to [0, 2^OUT_W-1], register.
- Offsets travel with the data, so every pixel uses one coherent bank.
- Cfg write: the edge with iCfgWe=1 writes the shadow entry at iCfgAddr. Addresses 12..15 are ignored. The active bank is never written directly.
- Commit: iCfgCommit=1 sets pending, and oCfgPending follows the next cycle. A repeat commit while pending has no effect.
- Swap (active<=shadow, pending<=0) happens on the first edge where pending (or commit this cycle) holds and either:
  - (a) iValid=1 and in_count==FRAME_PIXELS-1 (last pixel of frame accepted; that pixel still uses the old bank), or
  - (b) in_count==0 and iValid=0 (idle between frames).
- The new bank applies from the next accepted pixel. A write on the swap edge lands in shadow only, not in the swapped bank.
- in_count increments on each accepted pixel and wraps FRAME_PIXELS-1 -> 0.
- out_count does the same on oValid; oDone=1 when oValid and out_count==FRAME_PIXELS-1.
- Reset mid-frame: in-flight pixels are dropped, counters return to 0, and pending is cleared (any uncommitted shadow edits are lost to defaults).

Decomposition:
- Package csc_pkg: default coefficient/offset constants, cfg address enum (COEF0..COEF8, OFF0..OFF2), and the rounding-constant function.
- Sub-module csc_row_mac: one output row covering S2-S4 (3 multiplies, sum, round, offset, clamp). It is instantiated 3 times.
- The top level holds the banks, swap control, the S1 snapshot and the counters.

Test Plan:
1. Defaults, iData=FFFFFF -> oData={255,128,128} exactly 4 cycles later; iData=000000 -> {0,128,128}.
2. Defaults, iData=FF0000 -> {76,85,255}. This checks rounding and the top clamp (Cr 127.5+128=256 -> 255).
3. FRAME_PIXELS=4, 8 back-to-back pixels -> oDone pulses on the 4th and 8th oValid only.
4. FRAME_PIXELS=4; mid-frame, load diag 65536, zeros elsewhere, offsets 0, and commit after pixel 1.
   - Pixels 1-3 use defaults, and oCfgPending=1 until the edge accepting pixel 3 (count 3).
   - Pixel 4 of the next frame at 0x64C8FA -> {50,100,125}.
5. Negative clamp: row0 = {-65536,0,0}, offset 0, commit while idle -> swap on the next edge; input X=200 -> A=0.
6. Assert reset with 3 pixels in flight -> no oValid afterwards. Defaults are restored: white gives {255,128,128} 4 cycles after the next iValid.

Source files
------------

// File: rtl/csc_pkg.sv
// Shared constants for the colour-space converter: BT.601 defaults,
// the configuration address map and the rounding helper.
package csc_pkg;

    localparam int NUM_COEF = 9;
    localparam int NUM_OFF  = 3;

    // Configuration address map: row-major coefficients, then per-row offsets.
    typedef enum logic [3:0] {
        COEF0 = 4'd0,
        COEF1 = 4'd1,
        COEF2 = 4'd2,
        COEF3 = 4'd3,
        COEF4 = 4'd4,
        COEF5 = 4'd5,
        COEF6 = 4'd6,
        COEF7 = 4'd7,
        COEF8 = 4'd8,
        OFF0  = 4'd9,
        OFF1  = 4'd10,
        OFF2  = 4'd11
    } cfg_addr_e;

    // BT.601 RGB->YCbCr in Q1.17, offsets in integer output units.
    localparam int DEF_COEF [NUM_COEF] = '{
         39164,  76926,  14982,
        -22138, -43398,  65536,
         65536, -54906, -10630
    };
    localparam int DEF_OFF [NUM_OFF] = '{0, 128, 128};

    // Half an LSB of the integer result, added before truncation (round half up).
    function automatic int round_const(input int frac);
        return (frac > 0) ? (1 << (frac - 1)) : 0;
    endfunction

endpackage

// File: rtl/csc_row_mac.sv
// One output row of the matrix: multiply, sum/round, offset/clamp (S2..S4).
module csc_row_mac
    import csc_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int OUT_W     = 8,
    parameter int COEF_W    = 18,
    parameter int COEF_FRAC = 17,
    parameter int OFF_W     = 10
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [2:0][DATA_W:0]   x_i,
    input  logic [2:0][COEF_W-1:0] coef_i,
    input  logic [OFF_W-1:0]       off_i,
    output logic [OUT_W-1:0]       y_o
);

    localparam int PROD_W = DATA_W + 1 + COEF_W;
    localparam int SUM_W  = PROD_W + 2;
    localparam int RES_W  = SUM_W - COEF_FRAC;
    localparam int ACC_W  = ((RES_W > OFF_W) ? RES_W : OFF_W) + 1;
    localparam logic signed [SUM_W-1:0] RND   = SUM_W'(round_const(COEF_FRAC));
    localparam logic signed [ACC_W-1:0] MAX_V = ACC_W'((1 << OUT_W) - 1);

    logic signed [PROD_W-1:0] prod_q [3];
    logic signed [OFF_W-1:0]  off2_q, off3_q;
    logic signed [SUM_W-1:0]  sum_d;
    logic signed [RES_W-1:0]  res_q;
    logic signed [ACC_W-1:0]  acc_d;
    logic [OUT_W-1:0]         y_d, y_q;

    // S2: three signed products; the offset rides along with the pixel
    always_ff @(posedge clk) begin
        for (int k = 0; k < 3; k++)
            prod_q[k] <= PROD_W'($signed(x_i[k])) * PROD_W'($signed(coef_i[k]));
        off2_q <= $signed(off_i);
    end

    // S3 combinational: sum with guard bits plus the half-LSB rounding term
    always_comb begin
        sum_d = SUM_W'(prod_q[0]) + SUM_W'(prod_q[1]) + SUM_W'(prod_q[2]) + RND;
    end

    // S3: drop the fraction with an arithmetic shift (floor after +0.5)
    always_ff @(posedge clk) begin
        res_q  <= RES_W'(sum_d >>> COEF_FRAC);
        off3_q <= off2_q;
    end

    // S4 combinational: add offset and clamp to the unsigned output range
    always_comb begin
        acc_d = ACC_W'(res_q) + ACC_W'(off3_q);
        y_d   = acc_d[OUT_W-1:0];
        if (acc_d[ACC_W-1])
            y_d = '0;
        else if (acc_d > MAX_V)
            y_d = '1;
    end

    // S4: output register, cleared on reset so oData reads zero
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) y_q <= '0;
        else        y_q <= y_d;
    end

    assign y_o = y_q;

endmodule

// File: rtl/csc_matrix_pipe.sv
// Pipelined 3x3 colour-space converter with shadow/active coefficient
// banks that swap only on a frame boundary, plus frame-done tracking.
module csc_matrix_pipe
    import csc_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int OUT_W        = 8,
    parameter int COEF_W       = 18,
    parameter int COEF_FRAC    = 17,
    parameter int OFF_W        = 10,
    parameter int FRAME_PIXELS = 307200
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  iValid,
    input  logic [3*DATA_W-1:0]   iData,
    input  logic                  iCfgWe,
    input  logic [3:0]            iCfgAddr,
    input  logic [COEF_W-1:0]     iCfgData,
    input  logic                  iCfgCommit,
    output logic [3*OUT_W-1:0]    oData,
    output logic                  oValid,
    output logic                  oDone,
    output logic                  oCfgPending
);

    localparam int CNT_W = (FRAME_PIXELS > 1) ? $clog2(FRAME_PIXELS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_PIXELS - 1);

    logic [NUM_COEF-1:0][COEF_W-1:0] act_coef_q, sh_coef_q, coef_s1_q;
    logic [NUM_OFF-1:0][OFF_W-1:0]   act_off_q, sh_off_q, off_s1_q;
    logic [2:0][DATA_W:0]            x_s1_q;
    logic [3:0]                      vld_q;
    logic [CNT_W-1:0]                in_cnt_q, in_cnt_d, out_cnt_q, out_cnt_d;
    logic                            pend_q, pend_d, swap;
    logic [2:0][OUT_W-1:0]           y;

    // Swap when a commit is outstanding and we sit on a frame boundary:
    // either the last pixel is being accepted or the pipe is idle at count 0.
    assign swap = (pend_q | iCfgCommit) &
                  ((iValid & (in_cnt_q == CNT_LAST)) | (~iValid & (in_cnt_q == '0)));

    // Next-state for commit flag and the two pixel counters
    always_comb begin
        pend_d    = pend_q;
        in_cnt_d  = in_cnt_q;
        out_cnt_d = out_cnt_q;
        if (swap)            pend_d = 1'b0;
        else if (iCfgCommit) pend_d = 1'b1;
        if (iValid)
            in_cnt_d = (in_cnt_q == CNT_LAST) ? '0 : in_cnt_q + CNT_W'(1);
        if (oValid)
            out_cnt_d = (out_cnt_q == CNT_LAST) ? '0 : out_cnt_q + CNT_W'(1);
    end

    // Control state: commit flag, counters and the valid shift register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_q    <= 1'b0;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
            vld_q     <= '0;
        end else begin
            pend_q    <= pend_d;
            in_cnt_q  <= in_cnt_d;
            out_cnt_q <= out_cnt_d;
            vld_q     <= {vld_q[2:0], iValid};
        end
    end

    // Banks: writes land in shadow only; active is refreshed from the old
    // shadow contents on a swap edge, so a same-edge write waits for the next.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_COEF; i++) begin
                act_coef_q[i] <= COEF_W'(DEF_COEF[i]);
                sh_coef_q[i]  <= COEF_W'(DEF_COEF[i]);
            end
            for (int i = 0; i < NUM_OFF; i++) begin
                act_off_q[i] <= OFF_W'(DEF_OFF[i]);
                sh_off_q[i]  <= OFF_W'(DEF_OFF[i]);
            end
        end else begin
            if (swap) begin
                act_coef_q <= sh_coef_q;
                act_off_q  <= sh_off_q;
            end
            if (iCfgWe) begin
                for (int i = 0; i < NUM_COEF; i++)
                    if (iCfgAddr == 4'(int'(COEF0) + i)) sh_coef_q[i] <= iCfgData;
                for (int i = 0; i < NUM_OFF; i++)
                    if (iCfgAddr == 4'(int'(OFF0) + i)) sh_off_q[i] <= iCfgData[OFF_W-1:0];
            end
        end
    end

    // S1: zero-extended pixel plus a snapshot of the bank it must use
    always_ff @(posedge clk) begin
        for (int c = 0; c < 3; c++)
            x_s1_q[c] <= {1'b0, iData[(3-c)*DATA_W-1 -: DATA_W]};
        coef_s1_q <= act_coef_q;
        off_s1_q  <= act_off_q;
    end

    for (genvar r = 0; r < 3; r++) begin : g_row
        csc_row_mac #(
            .DATA_W    (DATA_W),
            .OUT_W     (OUT_W),
            .COEF_W    (COEF_W),
            .COEF_FRAC (COEF_FRAC),
            .OFF_W     (OFF_W)
        ) u_row (
            .clk    (clk),
            .reset  (reset),
            .x_i    (x_s1_q),
            .coef_i (coef_s1_q[3*r +: 3]),
            .off_i  (off_s1_q[r]),
            .y_o    (y[r])
        );
    end

    assign oData       = {y[0], y[1], y[2]};
    assign oValid      = vld_q[3];
    assign oDone       = vld_q[3] & (out_cnt_q == CNT_LAST);
    assign oCfgPending = pend_q;

endmodule

// File: tb/tb_csc_matrix_pipe.sv
// Directed + randomized bench for csc_matrix_pipe against an arithmetic model.
module tb_csc_matrix_pipe;

    localparam int FP = 4;
    localparam int DEF [12] = '{39164, 76926, 14982, -22138, -43398, 65536,
                                65536, -54906, -10630, 0, 128, 128};

    logic        clk        = 1'b0;
    logic        reset      = 1'b1;
    logic        iValid     = 1'b0;
    logic [23:0] iData      = '0;
    logic        iCfgWe     = 1'b0;
    logic [3:0]  iCfgAddr   = '0;
    logic [17:0] iCfgData   = '0;
    logic        iCfgCommit = 1'b0;
    logic [23:0] oData;
    logic        oValid, oDone, oCfgPending;

    csc_matrix_pipe #(
        .DATA_W(8), .OUT_W(8), .COEF_W(18), .COEF_FRAC(17), .OFF_W(10),
        .FRAME_PIXELS(FP)
    ) dut (
        .clk(clk), .reset(reset), .iValid(iValid), .iData(iData),
        .iCfgWe(iCfgWe), .iCfgAddr(iCfgAddr), .iCfgData(iCfgData),
        .iCfgCommit(iCfgCommit), .oData(oData), .oValid(oValid),
        .oDone(oDone), .oCfgPending(oCfgPending)
    );

    always #5 clk = ~clk;

    typedef struct { int due; logic [23:0] d; } exp_t;
    exp_t q[$];
    int  m_act [12];
    int  m_sh  [12];
    bit  m_pend;
    int  m_in, m_out, m_cyc;
    int  vectors = 0;
    int  miscompares = 0;
    int  n_done = 0;

    function automatic int sext(input int v, input int w);
        return (v <<< (32 - w)) >>> (32 - w);
    endfunction

    // Real-valued matrix product, rounded half up, offset, clamped to 0..255.
    function automatic logic [23:0] ref_pix(input logic [23:0] px, input int bank [12]);
        longint x [3];
        longint s;
        logic [23:0] res;
        x[0] = longint'(px[23:16]);
        x[1] = longint'(px[15:8]);
        x[2] = longint'(px[7:0]);
        res = '0;
        for (int i = 0; i < 3; i++) begin
            s = longint'(bank[3*i]) * x[0] + longint'(bank[3*i+1]) * x[1]
              + longint'(bank[3*i+2]) * x[2];
            s = ((s + 65536) >>> 17) + longint'(bank[9+i]);
            if (s < 0) s = 0;
            else if (s > 255) s = 255;
            res[8*(2-i) +: 8] = s[7:0];
        end
        return res;
    endfunction

    task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        bit ev, edn;
        logic [23:0] ed;
        ev  = (q.size() > 0) && (q[0].due == m_cyc);
        edn = 1'b0;
        ed  = '0;
        if (ev) begin
            ed  = q[0].d;
            void'(q.pop_front());
            edn = (m_out == FP - 1);
            m_out = (m_out + 1) % FP;
        end
        chk("oValid", oValid, ev);
        if (ev) chk("oData", oData, ed);
        chk("oDone", oDone, edn);
        chk("oCfgPending", oCfgPending, m_pend);
        if (oDone) n_done++;
    endtask

    // One clock: drive inputs, advance the model at the edge, check at negedge.
    task automatic cyc(input bit v, input logic [23:0] d, input bit we,
                       input int a, input int wd, input bit cm);
        bit sw;
        iValid = v; iData = d; iCfgWe = we;
        iCfgAddr = 4'(a); iCfgData = 18'(wd); iCfgCommit = cm;
        @(posedge clk);
        sw = (m_pend || cm) && ((v && m_in == FP - 1) || (!v && m_in == 0));
        if (v) begin
            q.push_back('{m_cyc + 3, ref_pix(d, m_act)});
            m_in = (m_in + 1) % FP;
        end
        if (sw) begin
            m_act  = m_sh;
            m_pend = 1'b0;
        end else if (cm) begin
            m_pend = 1'b1;
        end
        if (we && a < 9)       m_sh[a] = sext(wd, 18);
        else if (we && a < 12) m_sh[a] = sext(wd, 10);
        @(negedge clk);
        check_outputs();
        m_cyc++;
    endtask

    task automatic pix(input logic [23:0] d);  cyc(1'b1, d, 1'b0, 0, 0, 1'b0); endtask
    task automatic idle();                     cyc(1'b0, '0, 1'b0, 0, 0, 1'b0); endtask
    task automatic wr(input int a, input int wd); cyc(1'b0, '0, 1'b1, a, wd, 1'b0); endtask
    task automatic commit();                   cyc(1'b0, '0, 1'b0, 0, 0, 1'b1); endtask

    task automatic do_reset();
        iValid = 1'b0; iCfgWe = 1'b0; iCfgCommit = 1'b0;
        reset = 1'b0;
        q.delete();
        m_in = 0; m_out = 0; m_pend = 1'b0;
        m_act = DEF; m_sh = DEF;
        #1;
        chk("rst_oValid", oValid, 1'b0);
        chk("rst_oData", oData, 24'h0);
        chk("rst_oDone", oDone, 1'b0);
        chk("rst_oCfgPending", oCfgPending, 1'b0);
        repeat (2) @(negedge clk);
        chk("rst_hold_oValid", oValid, 1'b0);
        reset = 1'b1;
    endtask

    task automatic align_frame();
        logic [23:0] px;
        while (m_in != 0) begin
            px = 24'($urandom);
            pix(px);
        end
    endtask

    initial begin
        logic [23:0] px;
        int r, a, wd;
        m_cyc = 0;
        #1;
        do_reset();

        // Defaults: white, black, pure X (rounding + top clamp)
        pix(24'hFFFFFF); repeat (3) idle();
        chk("t1_white", oData, 24'hFF8080);
        pix(24'h000000); repeat (3) idle();
        chk("t1_black", oData, 24'h008080);
        pix(24'hFF0000); repeat (3) idle();
        chk("t2_red", oData, 24'h4C55FF);

        // Two back-to-back frames: oDone on the 4th and 8th outputs only
        align_frame();
        repeat (4) idle();
        n_done = 0;
        for (int i = 0; i < 8; i++) begin
            px = 24'($urandom);
            pix(px);
        end
        repeat (4) idle();
        chk("t3_done_count", 24'(n_done), 24'd2);

        // Mid-frame reload to diag 0.5, commit after pixel at count 1
        pix(24'h102030); pix(24'hA0B0C0);
        for (int i = 0; i < 9; i++) wr(i, (i % 4 == 0) ? 65536 : 0);
        for (int i = 9; i < 12; i++) wr(i, 0);
        commit();
        chk("t4_pending_set", oCfgPending, 1'b1);
        pix(24'h405060);
        chk("t4_pending_hold", oCfgPending, 1'b1);
        pix(24'hF0E0D0);
        chk("t4_pending_clear", oCfgPending, 1'b0);
        for (int i = 0; i < 4; i++) pix(24'h64C8FA);
        repeat (3) idle();
        chk("t4_diag", oData, 24'h32647D);

        // Negative clamp on row 0; commit while idle at frame start
        wr(0, -65536); wr(1, 0); wr(2, 0); wr(9, 0);
        commit();
        chk("t5_swapped", oCfgPending, 1'b0);
        pix(24'hC86432); repeat (3) idle();
        chk("t5_neg_clamp", oData, 24'h003219);

        // Random pixels, cfg writes (incl. ignored addresses) and commits
        for (int n = 0; n < 600; n++) begin
            r  = int'($urandom_range(0, 99));
            px = 24'($urandom);
            a  = int'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) wd = int'($urandom_range(0, 131072)) - 65536;
            else                           wd = int'($urandom_range(0, 262143));
            if (r < 60)      pix(px);
            else if (r < 75) wr(a, wd);
            else if (r < 80) commit();
            else if (r < 87) cyc(1'b1, px, 1'b1, a, wd, 1'b1);
            else             idle();
        end
        repeat (4) idle();

        // Reset with pixels in flight: nothing emerges, defaults restored
        for (int i = 0; i < 3; i++) begin
            px = 24'($urandom);
            pix(px);
        end
        do_reset();
        repeat (6) idle();
        pix(24'hFFFFFF); repeat (3) idle();
        chk("t6_white_after_reset", oData, 24'hFF8080);
        repeat (2) idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
